cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
Multi-cycle control FSM that sequences the 16-bit CPU datapath.
- Fetches an instruction from instruction memory over a req/ack handshake.
- Holds the instruction in an instruction register that feeds the instruction decoder.
- Uses the decoder's write-back and show flags to issue one-cycle strobes to the ALU, register file and display.
- Sits between instruction memory and the decoder, register file and ALU. Owns the PC, halt and fault status, and the retired-instruction count.

Parameters:
- PC_WIDTH, 8: width of program counter / instruction address.
- FETCH_TIMEOUT, 16: cycles in FETCH without ack before entering FAULT; range 2..255.
- HALT_INSTR, 16'hFFFF: encoding that halts the sequencer.

Ports:
- i_CLK  in  1  system clock, rising edge.
- i_RST_N  in  1  reset, asynchronous, active-low.
- i_Run  in  1  level; 1 = execute instructions continuously.
- o_IMemReq  out  1  fetch request to instruction memory.
- o_PC  out  PC_WIDTH  fetch address.
- i_IMemAck  in  1  instruction memory data valid.
- i_IMemData  in  16  instruction word.
- o_IR  out  16  latched instruction, drives decoder i_Instr.
- i_WriteBack  in  1  decoder flag: instruction writes a register.
- i_ShowR1  in  1  decoder flag: instruction displays R1.
- o_ALUEn  out  1  ALU result-capture strobe.
- o_RegWE  out  1  register file write strobe.
- o_ShowStrobe  out  1  display latch strobe.
- o_Retire  out  1  one-cycle pulse per completed instruction.
- o_InstrCount  out  16  retired-instruction counter.
- o_Halted  out  1  sticky halt status.
- o_Fault  out  1  sticky fetch-timeout status.
- o_State  out  3  current state encoding, for debug.

Behaviour:
- Reset (asynchronous, i_RST_N=0):
  - State goes to IDLE.
  - o_PC=0, o_IR=16'h0000, o_InstrCount=0.
  - All strobes, o_IMemReq, o_Halted and o_Fault are 0.
  - Reset mid-operation aborts the instruction immediately; nothing partial is retained.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, SHOW=5, HALT=6, FAULT=7.
- IDLE: o_IMemReq=0. If i_Run=1, go to FETCH next cycle.
- FETCH:
  - o_IMemReq=1 and o_PC held stable for the whole state.
  - On i_IMemAck=1: o_IR<=i_IMemData, PC<=PC+1 (wraps modulo 2^PC_WIDTH), timeout counter cleared, go to DECODE.
  - Ack may arrive in the first FETCH cycle.
  - If no ack after FETCH_TIMEOUT consecutive FETCH cycles, go to FAULT. The PC and IR are not updated in that case.
- DECODE: one settle cycle for the combinational decoder. If o_IR==HALT_INSTR, go to HALT (no retire); else go to EXEC.
- EXEC:
  - o_ALUEn=1 for exactly one cycle.
  - Next state: WB if i_WriteBack=1; else SHOW if i_ShowR1=1; else retire.
  - If both flags are set, WB runs first, then SHOW, then retire.
- WB: o_RegWE=1 for one cycle. Then SHOW if i_ShowR1=1, else retire.
- SHOW: o_ShowStrobe=1 for one cycle, then retire.
- Retire, on the cycle leaving the final state of an instruction:
  - o_Retire pulses for one cycle; o_InstrCount increments and wraps at 16'hFFFF to 0.
  - Next state is FETCH if i_Run=1, else IDLE.
- i_Run is sampled only in IDLE and at retire. Dropping it mid-instruction completes the current instruction.
- Latency with zero-wait ack: plain/PD1 instruction takes 3 cycles (FETCH, DECODE, EXEC); ADD takes 4 (adds WB); show takes 4 (adds SHOW).
- HALT: o_Halted=1, o_IMemReq=0. Leaves only on reset.
- FAULT: o_Fault=1, o_IMemReq=0. Leaves only on reset.
- Strobes are registered outputs and are mutually exclusive in any cycle.
- i_IMemAck outside FETCH is ignored.
- Decoder flags are sampled only in EXEC and WB.

Optional Feature:
Macro SEQ_SINGLE_STEP_EN.
- When defined, adds port i_Step (in, 1, rising-edge-detected internally).
- In IDLE with i_Run=0, a detected i_Step edge executes exactly one instruction, then returns to IDLE.
- A step edge arriving mid-instruction is ignored.
- When undefined, the port does not exist and IDLE leaves only on i_Run=1.

Test Plan:
- Reset, then i_Run=1; memory acks on the first FETCH cycle with 16'h(ADD encoding) at PC 0 -> o_IR latched, o_ALUEn at cycle 3, o_RegWE at cycle 4, o_Retire=1, o_PC=1, o_InstrCount=1.
- Three PD1 instructions, ack delayed 2 cycles each -> each retires 5 cycles apart, no o_RegWE/o_ShowStrobe, o_InstrCount=3, o_PC=3.
- Never assert ack -> FAULT after exactly 16 FETCH cycles; o_Fault=1, o_IMemReq=0, o_PC=0, o_IR unchanged.
- Fetch 16'hFFFF at PC 5 -> o_Halted=1, o_PC=6, o_InstrCount unchanged, no further requests; i_RST_N low returns all outputs to reset values.
- Preload PC to 8'hFF via 255 retired instructions, then one more -> o_PC wraps to 8'h00. Drop i_Run during EXEC -> instruction retires, state goes to IDLE.
- With SEQ_SINGLE_STEP_EN and i_Run=0, pulse i_Step twice -> exactly two retires, o_InstrCount=2, state returns to IDLE (0) after each.

Source files
------------

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//   Multi-cycle control FSM for the 16-bit CPU datapath. It fetches a word from
//   instruction memory over a req/ack handshake and holds it in the instruction
//   register that feeds the decoder. It then issues one-cycle strobes to the
//   ALU, register file and display, using the decoder's write-back and show
//   flags. It owns the PC, the sticky halt and fault status and the
//   retired-instruction counter.
//
//   Optional feature: define SEQ_SINGLE_STEP_EN to add i_Step. With i_Run low,
//   a rising edge on i_Step runs exactly one instruction from IDLE.
//
// Ports
//   i_CLK, i_RST_N   clock (rising edge), asynchronous active-low reset
//   i_Run            level; 1 = execute continuously
//   i_Step           (SEQ_SINGLE_STEP_EN only) single-step request, edge detected
//   o_IMemReq        fetch request, high for the whole FETCH state
//   o_PC             fetch address
//   i_IMemAck        instruction memory data valid (honoured only in FETCH)
//   i_IMemData       instruction word
//   o_IR             latched instruction, drives the decoder
//   i_WriteBack      decoder flag: instruction writes a register
//   i_ShowR1         decoder flag: instruction displays R1
//   o_ALUEn          ALU result-capture strobe
//   o_RegWE          register file write strobe
//   o_ShowStrobe     display latch strobe
//   o_Retire         one-cycle pulse per completed instruction
//   o_InstrCount     retired-instruction counter (wraps)
//   o_Halted         sticky halt status
//   o_Fault          sticky fetch-timeout status
//   o_State          current state encoding, for debug
// -----------------------------------------------------------------------------
module cpu_sequencer #(
   parameter int          PC_WIDTH      = 8,
   parameter int          FETCH_TIMEOUT = 16,
   parameter logic [15:0] HALT_INSTR    = 16'hFFFF
) (
   input  logic                i_CLK,
   input  logic                i_RST_N,
   input  logic                i_Run,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic                i_Step,
`endif
   output logic                o_IMemReq,
   output logic [PC_WIDTH-1:0] o_PC,
   input  logic                i_IMemAck,
   input  logic [15:0]         i_IMemData,
   output logic [15:0]         o_IR,
   input  logic                i_WriteBack,
   input  logic                i_ShowR1,
   output logic                o_ALUEn,
   output logic                o_RegWE,
   output logic                o_ShowStrobe,
   output logic                o_Retire,
   output logic [15:0]         o_InstrCount,
   output logic                o_Halted,
   output logic                o_Fault,
   output logic [2:0]          o_State
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_SHOW   = 3'd5,
      S_HALT   = 3'd6,
      S_FAULT  = 3'd7
   } state_t;

   // Last FETCH cycle index before giving up (counter starts at 0).
   localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

   state_t     state;
   logic [7:0] tmo_cnt;
   logic       start;
   logic       retire_now;

`ifdef SEQ_SINGLE_STEP_EN
   logic step_q;
   // A step edge only matters in IDLE; elsewhere the IDLE branch is not taken.
   assign start = i_Run | (i_Step & ~step_q);
`else
   assign start = i_Run;
`endif

   // Final state of an instruction: nothing further is owed after this cycle.
   assign retire_now = ((state == S_EXEC) && !i_WriteBack && !i_ShowR1) ||
                       ((state == S_WB)   && !i_ShowR1) ||
                       (state == S_SHOW);

   assign o_State = state;

   // NOTE: every register here is state, so all assignments are non-blocking;
   // a blocking write would let later statements see the new value this cycle.
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         state        <= S_IDLE;
         tmo_cnt      <= '0;
         o_IMemReq    <= 1'b0;
         o_PC         <= '0;
         o_IR         <= '0;
         o_ALUEn      <= 1'b0;
         o_RegWE      <= 1'b0;
         o_ShowStrobe <= 1'b0;
         o_Retire     <= 1'b0;
         o_InstrCount <= '0;
         o_Halted     <= 1'b0;
         o_Fault      <= 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
         step_q       <= 1'b0;
`endif
      end else begin
`ifdef SEQ_SINGLE_STEP_EN
         step_q <= i_Step;
`endif
         // NOTE: pulse outputs default low each cycle and are raised only on
         // entry to the state that owns them, which keeps them one cycle wide.
         o_ALUEn      <= 1'b0;
         o_RegWE      <= 1'b0;
         o_ShowStrobe <= 1'b0;
         o_Retire     <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_FETCH;
                  o_IMemReq <= 1'b1;
                  tmo_cnt   <= '0;
               end
            end
            S_FETCH: begin
               if (i_IMemAck) begin
                  o_IR      <= i_IMemData;
                  o_PC      <= o_PC + PC_WIDTH'(1);
                  tmo_cnt   <= '0;
                  o_IMemReq <= 1'b0;
                  state     <= S_DECODE;
               end else if (tmo_cnt == TMO_LAST) begin
                  o_IMemReq <= 1'b0;
                  o_Fault   <= 1'b1;
                  state     <= S_FAULT;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            S_DECODE: begin
               if (o_IR == HALT_INSTR) begin
                  o_Halted <= 1'b1;
                  state    <= S_HALT;
               end else begin
                  o_ALUEn <= 1'b1;
                  state   <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (i_WriteBack) begin
                  o_RegWE <= 1'b1;
                  state   <= S_WB;
               end else if (i_ShowR1) begin
                  o_ShowStrobe <= 1'b1;
                  state        <= S_SHOW;
               end
            end
            S_WB: begin
               if (i_ShowR1) begin
                  o_ShowStrobe <= 1'b1;
                  state        <= S_SHOW;
               end
            end
            S_SHOW:  ;
            S_HALT:  ;
            S_FAULT: ;
            default: state <= S_IDLE;
         endcase

         // Retire overrides the per-state next-state choice above.
         if (retire_now) begin
            o_Retire     <= 1'b1;
            o_InstrCount <= o_InstrCount + 16'd1;
            o_IMemReq    <= i_Run;
            tmo_cnt      <= '0;
            state        <= i_Run ? S_FETCH : S_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
//   Self-checking bench for cpu_sequencer. A memory responder with randomized
//   ack latency and a stand-in decoder (bit0 = write-back, bit1 = show) drive
//   the DUT. A transaction-level model records each fetch and predicts the
//   instruction's duration, strobes, PC and count, then compares them at retire.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

   localparam int FETCH_TIMEOUT = 16;
   localparam int NEVER         = 100000;

   logic        i_CLK = 1'b0;
   logic        i_RST_N;
   logic        i_Run;
`ifdef SEQ_SINGLE_STEP_EN
   logic        i_Step;
`endif
   logic        o_IMemReq;
   logic [7:0]  o_PC;
   logic        i_IMemAck;
   logic [15:0] i_IMemData;
   logic [15:0] o_IR;
   logic        i_WriteBack;
   logic        i_ShowR1;
   logic        o_ALUEn, o_RegWE, o_ShowStrobe, o_Retire;
   logic [15:0] o_InstrCount;
   logic        o_Halted, o_Fault;
   logic [2:0]  o_State;

   cpu_sequencer #(.PC_WIDTH(8), .FETCH_TIMEOUT(FETCH_TIMEOUT), .HALT_INSTR(16'hFFFF)) dut (
      .i_CLK        (i_CLK),
      .i_RST_N      (i_RST_N),
      .i_Run        (i_Run),
`ifdef SEQ_SINGLE_STEP_EN
      .i_Step       (i_Step),
`endif
      .o_IMemReq    (o_IMemReq),
      .o_PC         (o_PC),
      .i_IMemAck    (i_IMemAck),
      .i_IMemData   (i_IMemData),
      .o_IR         (o_IR),
      .i_WriteBack  (i_WriteBack),
      .i_ShowR1     (i_ShowR1),
      .o_ALUEn      (o_ALUEn),
      .o_RegWE      (o_RegWE),
      .o_ShowStrobe (o_ShowStrobe),
      .o_Retire     (o_Retire),
      .o_InstrCount (o_InstrCount),
      .o_Halted     (o_Halted),
      .o_Fault      (o_Fault),
      .o_State      (o_State)
   );

   always #5 i_CLK = ~i_CLK;

   // Stand-in decoder: flags are a pure function of the latched instruction.
   assign i_WriteBack = o_IR[0];
   assign i_ShowR1    = o_IR[1];

   typedef struct {
      int          d;
      logic [15:0] w;
      logic [7:0]  pc;
   } fetch_t;

   logic [15:0] mem [256];
   fetch_t      pend [$];

   int checks = 0, errors = 0, cyc = 0;
   int fetch_wait, cur_delay, fetch_idx;
   int fixed_delay = -1, no_ack_from = -1;
   int instr_cycles, fetch_cycles, n_alu, n_we, n_sh, retires;
   int r0, budget;
   logic [15:0] exp_count;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Ack latency for the next fetch, in FETCH cycles without ack.
   function automatic int next_delay();
      fetch_idx++;
      if (no_ack_from >= 0 && fetch_idx > no_ack_from) return NEVER;
      if (fixed_delay >= 0) return fixed_delay;
      if ($urandom_range(0, 9) == 0) return FETCH_TIMEOUT - 1;
      return int'($urandom_range(0, 3));
   endfunction

   // Runs at each falling edge: scores retirements, tracks strobes, and drives
   // the memory response for the coming rising edge.
   task automatic monitor();
      fetch_t f;
      if (o_Retire) begin
         retires++;
         exp_count = exp_count + 16'd1;
         if (pend.size() == 0) begin
            check("retire_without_fetch", 32'd1, 32'd0);
         end else begin
            f = pend.pop_front();
            check("instr_cycles", instr_cycles, f.d + 3 + int'(f.w[0]) + int'(f.w[1]));
            check("retire_ir",    o_IR, f.w);
            check("retire_pc",    o_PC, 8'(f.pc + 8'd1));
            check("instr_count",  o_InstrCount, exp_count);
            check("alu_pulses",   n_alu, 1);
            check("regwe_pulses", n_we, int'(f.w[0]));
            check("show_pulses",  n_sh, int'(f.w[1]));
         end
         instr_cycles = 0; fetch_cycles = 0; n_alu = 0; n_we = 0; n_sh = 0;
      end
      if (o_State >= 3'd1 && o_State <= 3'd5) instr_cycles++;
      if (o_State == 3'd1) fetch_cycles++;
      n_alu += int'(o_ALUEn);
      n_we  += int'(o_RegWE);
      n_sh  += int'(o_ShowStrobe);
      check("strobes_exclusive", 32'($countones({o_ALUEn, o_RegWE, o_ShowStrobe}) <= 1), 32'd1);
      check("req_only_in_fetch", o_IMemReq, o_State == 3'd1);

      if (o_IMemReq) begin
         if (fetch_wait == cur_delay) begin
            i_IMemAck  = 1'b1;
            i_IMemData = mem[o_PC];
            pend.push_back('{d: cur_delay, w: mem[o_PC], pc: o_PC});
            fetch_wait = 0;
            cur_delay  = next_delay();
         end else begin
            i_IMemAck  = 1'b0;
            i_IMemData = 16'($urandom);
            fetch_wait++;
         end
      end else begin
         // Stray acks outside FETCH must be ignored by the DUT.
         i_IMemAck  = 1'($urandom_range(0, 1));
         i_IMemData = 16'($urandom);
      end
   endtask

   task automatic step();
      @(posedge i_CLK);
      @(negedge i_CLK);
      cyc++;
      monitor();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"},  o_State, 3'd0);
      check({tag, "_pc"},     o_PC, 8'd0);
      check({tag, "_ir"},     o_IR, 16'h0000);
      check({tag, "_count"},  o_InstrCount, 16'd0);
      check({tag, "_req"},    o_IMemReq, 1'b0);
      check({tag, "_strobes"}, {o_ALUEn, o_RegWE, o_ShowStrobe, o_Retire}, 4'b0000);
      check({tag, "_halted"}, o_Halted, 1'b0);
      check({tag, "_fault"},  o_Fault, 1'b0);
   endtask

   // Asserts reset between clock edges so its effect is visible without a clock.
   task automatic do_reset(input string tag);
      @(negedge i_CLK);
      i_Run = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
      i_Step = 1'b0;
`endif
      #2 i_RST_N = 1'b0;
      #1 check_reset_values(tag);
      pend.delete();
      instr_cycles = 0; fetch_cycles = 0; n_alu = 0; n_we = 0; n_sh = 0;
      retires = 0; exp_count = 16'd0;
      fetch_wait = 0; fetch_idx = 0;
      cur_delay = next_delay();
      i_IMemAck = 1'b0;
      repeat (2) @(negedge i_CLK);
      i_RST_N = 1'b1;
   endtask

   task automatic fill_mem();
      for (int i = 0; i < 256; i++) begin
         mem[i] = 16'($urandom);
         if (mem[i] == 16'hFFFF) mem[i] = 16'h0000;
      end
   endtask

   task automatic run_until_retires(input int n, input int limit);
      budget = limit;
      while (retires < n && budget > 0) begin
         step();
         budget--;
      end
      check("retire_wait_budget", 32'(retires >= n), 32'd1);
   endtask

   initial begin
      i_RST_N = 1'b0; i_Run = 1'b0; i_IMemAck = 1'b0; i_IMemData = 16'h0;
`ifdef SEQ_SINGLE_STEP_EN
      i_Step = 1'b0;
`endif
      fill_mem();

      // Directed ADD-like instruction with zero-wait ack.
      mem[0] = 16'h1001;
      fixed_delay = 0;
      do_reset("rst0");
      i_Run = 1'b1;
      step(); check("add_c1_req", o_IMemReq, 1'b1); check("add_c1_pc", o_PC, 8'd0);
      step(); check("add_c2_state", o_State, 3'd2); check("add_c2_ir", o_IR, 16'h1001);
      step(); check("add_c3_alu", o_ALUEn, 1'b1);
      step(); check("add_c4_regwe", o_RegWE, 1'b1);
      step(); check("add_retire", o_Retire, 1'b1);
      check("add_pc", o_PC, 8'd1); check("add_count", o_InstrCount, 16'd1);

      // Three plain instructions, ack delayed two cycles each.
      fill_mem();
      for (int i = 0; i < 4; i++) mem[i] = mem[i] & 16'hFFFC;
      fixed_delay = 2;
      do_reset("rst1");
      i_Run = 1'b1;
      run_until_retires(3, 60);
      check("pd1_count", o_InstrCount, 16'd3);
      check("pd1_pc", o_PC, 8'd3);
      i_Run = 1'b0;
      repeat (30) step();
      check("pd1_drop_retires", retires, 4);
      check("pd1_drop_idle", o_State, 3'd0);

      // Long randomized run: PC wrap, random ack latency, random Run drops.
      fill_mem();
      fixed_delay = -1;
      do_reset("rst2");
      i_Run = 1'b1;
      budget = 20000;
      while (retires < 300 && budget > 0) begin
         step();
         budget--;
         if (o_Retire && retires == 256) check("pc_wrap", o_PC, 8'd0);
         if ($urandom_range(0, 59) == 0) begin
            r0 = retires;
            i_Run = 1'b0;
            repeat (30) step();
            check("drop_one_retire", retires - r0, 1);
            check("drop_idle", o_State, 3'd0);
            i_Run = 1'b1;
         end
      end
      check("random_run_budget", 32'(retires >= 300), 32'd1);
      // Reset lands mid-instruction here.
      do_reset("rst_mid");

      // HALT instruction at PC 5.
      fill_mem();
      mem[5] = 16'hFFFF;
      do_reset("rst3");
      i_Run = 1'b1;
      budget = 300;
      while (o_State != 3'd6 && budget > 0) begin step(); budget--; end
      check("halt_reached", o_State, 3'd6);
      check("halt_flag", o_Halted, 1'b1);
      check("halt_pc", o_PC, 8'd6);
      check("halt_count", o_InstrCount, 16'd5);
      repeat (20) step();
      check("halt_sticky", o_State, 3'd6);
      check("halt_no_retire", retires, 5);
      check("halt_fault_clear", o_Fault, 1'b0);
      do_reset("rst_halt");

      // Fetch timeout after two good instructions.
      fill_mem();
      fixed_delay = 1; no_ack_from = 2;
      do_reset("rst4");
      i_Run = 1'b1;
      budget = 200;
      while (o_State != 3'd7 && budget > 0) begin step(); budget--; end
      check("fault_reached", o_State, 3'd7);
      check("fault_fetch_cycles", fetch_cycles, FETCH_TIMEOUT);
      check("fault_flag", o_Fault, 1'b1);
      check("fault_pc", o_PC, 8'd2);
      check("fault_ir", o_IR, mem[1]);
      check("fault_count", o_InstrCount, 16'd2);
      repeat (10) step();
      check("fault_sticky", o_State, 3'd7);
      no_ack_from = -1; fixed_delay = -1;
      do_reset("rst_fault");

`ifdef SEQ_SINGLE_STEP_EN
      // Single-step: a held step pulse runs exactly one instruction.
      fill_mem();
      do_reset("rst5");
      for (int k = 0; k < 2; k++) begin
         r0 = retires;
         i_Step = 1'b1;
         repeat (3) step();
         i_Step = 1'b0;
         repeat (30) step();
         check("step_one_retire", retires - r0, 1);
         check("step_idle", o_State, 3'd0);
      end
      check("step_count", o_InstrCount, 16'd2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
